mem_stage: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: takes the p3_* bundle (ALU slot + MEM slot), runs the

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs the byte-wide data-memory req/ack transaction for the p3 bundle,
// stalls the front of the pipe while waiting, keeps the NZCV flags and loads the MEM/WB register.
module mem_stage #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MEM_flush,
   input  logic              p3_memRead,
   input  logic              p3_memWrite,
   input  logic              p3_alu_regWrite,
   input  logic              p3_mem_regWrite,
   input  logic              p3_flag_regWrite,
   input  logic [2:0]        p3_alu_rd,
   input  logic [2:0]        p3_mem_rd,
   input  logic [7:0]        p3_mem_reg_rd,
   input  logic [31:0]       p3_alu_aluOut,
   input  logic [31:0]       p3_mem_address,
   input  logic              p3_flag_z,
   input  logic              p3_flag_n,
   input  logic              p3_flag_c,
   input  logic              p3_flag_v,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [7:0]        dmem_wdata,
   input  logic              dmem_ack,
   input  logic [7:0]        dmem_rdata,
   output logic              mem_stall,
   output logic              dmem_err,
   output logic              p4_alu_regWrite,
   output logic              p4_mem_regWrite,
   output logic [2:0]        p4_alu_rd,
   output logic [2:0]        p4_mem_rd,
   output logic [31:0]       p4_alu_result,
   output logic [31:0]       p4_mem_data,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              flag_v
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;
   logic [7:0]        r_rdata;
   logic              r_err;

   logic w_mem_op;
   logic w_stall;
   logic w_req_nxt;
   logic w_start;
   logic w_capture;
   logic w_abort;
   logic w_count;
   logic w_p4_load;
   logic w_from_done;

   assign w_mem_op    = (p3_memRead | p3_memWrite) & ~MEM_flush;
   assign w_from_done = (r_state == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_req_nxt   = 1'b0;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      w_count     = 1'b0;
      w_p4_load   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               w_stall     = 1'b1;
               w_start     = 1'b1;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_ACCESS;
            end else begin
               w_p4_load = 1'b1;
            end
         end
         S_ACCESS: begin
            // MEM_flush is deliberately ignored once the bus transaction is in flight
            w_stall = 1'b1;
            if (dmem_ack) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_abort     = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_count   = 1'b1;
               w_req_nxt = 1'b1;
            end
         end
         S_DONE: begin
            w_p4_load   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         if (w_start) begin
            r_cnt   <= '0;
            r_we    <= p3_memWrite;
            r_addr  <= p3_mem_address[ADDR_W-1:0];
            r_wdata <= p3_mem_reg_rd;
         end else if (w_count) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_capture) begin
            r_rdata <= dmem_rdata;
         end else if (w_abort) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   // MEM/WB register: stalled or flushed cycles insert a bubble by clearing only the write enables
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p4_alu_regWrite <= 1'b0;
         p4_mem_regWrite <= 1'b0;
         p4_alu_rd       <= '0;
         p4_mem_rd       <= '0;
         p4_alu_result   <= '0;
         p4_mem_data     <= '0;
         flag_z          <= 1'b0;
         flag_n          <= 1'b0;
         flag_c          <= 1'b0;
         flag_v          <= 1'b0;
      end else if (w_p4_load && !MEM_flush) begin
         p4_alu_regWrite <= p3_alu_regWrite;
         p4_mem_regWrite <= p3_mem_regWrite;
         p4_alu_rd       <= p3_alu_rd;
         p4_mem_rd       <= p3_mem_rd;
         p4_alu_result   <= p3_alu_aluOut;
         p4_mem_data     <= w_from_done ? {24'b0, r_rdata} : 32'b0;
         if (p3_flag_regWrite) begin
            flag_z <= p3_flag_z;
            flag_n <= p3_flag_n;
            flag_c <= p3_flag_c;
            flag_v <= p3_flag_v;
         end
      end else begin
         p4_alu_regWrite <= 1'b0;
         p4_mem_regWrite <= 1'b0;
      end
   end

   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign dmem_err   = r_err;
   assign mem_stall  = w_stall;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes, timeout, flush and reset.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        MEM_flush;
   logic        p3_memRead, p3_memWrite;
   logic        p3_alu_regWrite, p3_mem_regWrite, p3_flag_regWrite;
   logic [2:0]  p3_alu_rd, p3_mem_rd;
   logic [7:0]  p3_mem_reg_rd;
   logic [31:0] p3_alu_aluOut, p3_mem_address;
   logic        p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v;
   logic        dmem_req, dmem_we;
   logic [7:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        dmem_ack;
   logic [7:0]  dmem_rdata;
   logic        mem_stall, dmem_err;
   logic        p4_alu_regWrite, p4_mem_regWrite;
   logic [2:0]  p4_alu_rd, p4_mem_rd;
   logic [31:0] p4_alu_result, p4_mem_data;
   logic        flag_z, flag_n, flag_c, flag_v;

   int vectors = 0;
   int miscompares = 0;

   mem_stage #(.ADDR_W(8), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .MEM_flush(MEM_flush),
      .p3_memRead(p3_memRead), .p3_memWrite(p3_memWrite),
      .p3_alu_regWrite(p3_alu_regWrite), .p3_mem_regWrite(p3_mem_regWrite),
      .p3_flag_regWrite(p3_flag_regWrite), .p3_alu_rd(p3_alu_rd), .p3_mem_rd(p3_mem_rd),
      .p3_mem_reg_rd(p3_mem_reg_rd), .p3_alu_aluOut(p3_alu_aluOut),
      .p3_mem_address(p3_mem_address), .p3_flag_z(p3_flag_z), .p3_flag_n(p3_flag_n),
      .p3_flag_c(p3_flag_c), .p3_flag_v(p3_flag_v),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .dmem_err(dmem_err),
      .p4_alu_regWrite(p4_alu_regWrite), .p4_mem_regWrite(p4_mem_regWrite),
      .p4_alu_rd(p4_alu_rd), .p4_mem_rd(p4_mem_rd), .p4_alu_result(p4_alu_result),
      .p4_mem_data(p4_mem_data), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      MEM_flush = 0; p3_memRead = 0; p3_memWrite = 0;
      p3_alu_regWrite = 0; p3_mem_regWrite = 0; p3_flag_regWrite = 0;
      p3_alu_rd = 0; p3_mem_rd = 0; p3_mem_reg_rd = 0;
      p3_alu_aluOut = 0; p3_mem_address = 0;
      p3_flag_z = 0; p3_flag_n = 0; p3_flag_c = 0; p3_flag_v = 0;
      dmem_ack = 0; dmem_rdata = 0;
   endtask

   initial begin
      reset = 0;
      nop();
      step();
      step();
      chk("rst_req", dmem_req, 0);
      chk("rst_err", dmem_err, 0);
      chk("rst_p4_result", p4_alu_result, 0);
      chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      reset = 1;
      step();

      // 1: ALU-only bundle passes straight through
      p3_alu_regWrite = 1; p3_alu_rd = 3; p3_alu_aluOut = 32'h12345678;
      p3_flag_regWrite = 1; p3_flag_z = 0; p3_flag_n = 1; p3_flag_c = 0; p3_flag_v = 1;
      #1;
      chk("t1_stall", mem_stall, 0);
      step();
      chk("t1_result", p4_alu_result, 32'h12345678);
      chk("t1_rd", p4_alu_rd, 3);
      chk("t1_we", p4_alu_regWrite, 1);
      chk("t1_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);

      // 2: load from 0x24 (upper address bits dropped), ack on second ACCESS cycle
      p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_rd = 5; p3_mem_address = 32'h0000_1124;
      p3_alu_rd = 2; p3_alu_aluOut = 32'hCAFE0001;
      p3_flag_z = 1; p3_flag_n = 0; p3_flag_c = 1; p3_flag_v = 0;
      #1;
      chk("t2_stall_idle", mem_stall, 1);
      chk("t2_req_idle", dmem_req, 0);
      step();
      chk("t2_req_a1", dmem_req, 1);
      chk("t2_we", dmem_we, 0);
      chk("t2_addr", dmem_addr, 8'h24);
      chk("t2_stall_a1", mem_stall, 1);
      chk("t2_bubble", p4_alu_regWrite, 0);
      chk("t2_hold_result", p4_alu_result, 32'h12345678);
      chk("t2_flags_hold", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
      step();
      dmem_ack = 1; dmem_rdata = 8'hA5;
      #1;
      chk("t2_stall_a2", mem_stall, 1);
      chk("t2_req_a2", dmem_req, 1);
      step();
      dmem_ack = 0; dmem_rdata = 8'h00;
      #1;
      chk("t2_stall_done", mem_stall, 0);
      chk("t2_req_done", dmem_req, 0);
      step();
      chk("t2_mem_data", p4_mem_data, 32'h000000A5);
      chk("t2_mem_rd", p4_mem_rd, 5);
      chk("t2_mem_we", p4_mem_regWrite, 1);
      chk("t2_alu_result", p4_alu_result, 32'hCAFE0001);
      chk("t2_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);

      // 3: store 0x5C to 0x10, ack on first ACCESS cycle
      nop();
      p3_memWrite = 1; p3_mem_reg_rd = 8'h5C; p3_mem_address = 32'h10;
      #1;
      chk("t3_stall_idle", mem_stall, 1);
      step();
      dmem_ack = 1;
      #1;
      chk("t3_req", dmem_req, 1);
      chk("t3_we", dmem_we, 1);
      chk("t3_wdata", dmem_wdata, 8'h5C);
      chk("t3_addr", dmem_addr, 8'h10);
      chk("t3_stall_a1", mem_stall, 1);
      step();
      dmem_ack = 0;
      #1;
      chk("t3_stall_done", mem_stall, 0);
      step();
      chk("t3_mem_we", p4_mem_regWrite, 0);
      chk("t3_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);

      // ack with no transaction in flight is ignored
      nop();
      dmem_ack = 1;
      step();
      dmem_ack = 0;
      chk("stray_ack_req", dmem_req, 0);
      chk("stray_ack_err", dmem_err, 0);

      // 4: load never acknowledged -> 16 request cycles, then abort with error
      p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_rd = 1; p3_mem_address = 32'h33;
      step();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t4_req_%0d", i), dmem_req, 1);
         chk($sformatf("t4_stall_%0d", i), mem_stall, 1);
         step();
      end
      chk("t4_req_done", dmem_req, 0);
      chk("t4_stall_done", mem_stall, 0);
      chk("t4_err", dmem_err, 1);
      step();
      chk("t4_mem_data", p4_mem_data, 0);
      chk("t4_mem_we", p4_mem_regWrite, 1);
      nop();
      step();
      chk("t4_err_sticky", dmem_err, 1);

      // 6: flush in IDLE squashes a pending load and its flag update
      p3_memRead = 1; p3_mem_regWrite = 1; p3_alu_regWrite = 1; p3_flag_regWrite = 1;
      p3_mem_address = 32'h44; MEM_flush = 1;
      #1;
      chk("t6_stall", mem_stall, 0);
      step();
      chk("t6_req", dmem_req, 0);
      chk("t6_alu_we", p4_alu_regWrite, 0);
      chk("t6_mem_we", p4_mem_regWrite, 0);
      chk("t6_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
      nop();
      step();

      // flush is ignored during ACCESS but bubbles the bundle in DONE
      p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_address = 32'h40;
      p3_flag_regWrite = 1; p3_flag_v = 1;
      step();
      MEM_flush = 1; dmem_ack = 1; dmem_rdata = 8'h3C;
      #1;
      chk("t7_req", dmem_req, 1);
      chk("t7_stall", mem_stall, 1);
      step();
      dmem_ack = 0;
      #1;
      chk("t7_stall_done", mem_stall, 0);
      step();
      chk("t7_mem_we", p4_mem_regWrite, 0);
      chk("t7_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
      nop();
      step();

      // 5: reset during ACCESS drops the request immediately and clears everything
      p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_address = 32'h55;
      step();
      chk("t5_req_before", dmem_req, 1);
      reset = 0;
      #1;
      chk("t5_req_async", dmem_req, 0);
      nop();
      step();
      reset = 1;
      step();
      chk("t5_req_after", dmem_req, 0);
      chk("t5_stall_after", mem_stall, 0);
      chk("t5_p4_result", p4_alu_result, 0);
      chk("t5_p4_data", p4_mem_data, 0);
      chk("t5_p4_we", {p4_alu_regWrite, p4_mem_regWrite}, 0);
      chk("t5_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      chk("t5_err", dmem_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
